// File: rtl/icache_responder.sv
// icache_responder: direct-mapped, word-per-line instruction cache answering one fetch at a time.
// Optional ICACHE_PERF_EN adds hit_cnt/miss_cnt counters.
module icache_responder #(
  parameter int INDEX_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ins_asked,
  input  logic [31:0] ins_addr,
  output logic        ic_rdy,
  output logic [31:0] ins,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_rdy,
`ifdef ICACHE_PERF_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  input  logic [31:0] mc_data
);
  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;
  typedef enum logic {IDLE, MEM_WAIT} state_t;
  state_t                  r_state;
  logic [31:0]             r_data [LINES];
  logic [TAG_BITS-1:0]     r_tag  [LINES];
  logic [LINES-1:0]        r_valid;
  logic [INDEX_BITS-1:0]   r_idx;
  logic [TAG_BITS-1:0]     r_ltag;
  logic [INDEX_BITS-1:0]   w_idx;
  logic [TAG_BITS-1:0]     w_tag;
  logic                    w_hit;
  logic                    w_accept;
  logic                    w_fill;
  logic                    w_unused;
  assign w_idx    = ins_addr[INDEX_BITS+1:2];
  assign w_tag    = ins_addr[31:INDEX_BITS+2];
  assign w_hit    = r_valid[w_idx] && r_tag[w_idx] == w_tag;
  // Requests overlapping an outstanding response are protocol violations and are dropped.
  assign w_accept = r_state == IDLE && ins_asked && !ic_rdy;
  assign w_fill   = !rst && rdy && r_state == MEM_WAIT && mc_rdy;
  assign w_unused = ^ins_addr[1:0];
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[r_idx] <= mc_data;
      r_tag[r_idx]  <= r_ltag;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      ic_rdy   <= 1'b0;
      mc_req   <= 1'b0;
      ins      <= '0;
      mc_addr  <= '0;
      r_valid  <= '0;
      r_idx    <= '0;
      r_ltag   <= '0;
`ifdef ICACHE_PERF_EN
      hit_cnt  <= '0;
      miss_cnt <= '0;
`endif
    end else if (rdy) begin
      mc_req <= 1'b0;
      ic_rdy <= 1'b0;
      if (w_accept && w_hit) begin
        ic_rdy <= 1'b1;
        ins    <= r_data[w_idx];
`ifdef ICACHE_PERF_EN
        hit_cnt <= hit_cnt + 32'd1;
`endif
      end else if (w_accept) begin
        mc_req  <= 1'b1;
        mc_addr <= {ins_addr[31:2], 2'b00};
        r_idx   <= w_idx;
        r_ltag  <= w_tag;
        r_state <= MEM_WAIT;
`ifdef ICACHE_PERF_EN
        miss_cnt <= miss_cnt + 32'd1;
`endif
      end
      if (w_fill) begin
        r_valid[r_idx] <= 1'b1;
        ic_rdy         <= 1'b1;
        ins            <= mc_data;
        r_state        <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: table-driven directed vectors plus reset/stall sequences for icache_responder.
module tb_icache_responder;
  logic        clk = 1'b0;
  logic        rst, rdy, ins_asked, mc_rdy;
  logic [31:0] ins_addr, mc_data;
  logic        ic_rdy, mc_req;
  logic [31:0] ins, mc_addr;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        rst, rdy, ask;
    logic [31:0] addr;
    logic        mrdy;
    logic [31:0] mdata;
    logic        e_icrdy, e_mcreq;
    logic [31:0] e_mcaddr, e_ins;
    logic        c_ins;
  } vec_t;
  vec_t v[$];
  always #5 clk = ~clk;
  icache_responder #(.INDEX_BITS(8)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .ins_asked(ins_asked), .ins_addr(ins_addr),
    .ic_rdy(ic_rdy), .ins(ins), .mc_req(mc_req), .mc_addr(mc_addr),
    .mc_rdy(mc_rdy),
`ifdef ICACHE_PERF_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .mc_data(mc_data)
  );
  always @(posedge clk)
    if (rdy && !rst && ins_asked && (ic_rdy || mc_req)) begin
      errors++;
      $display("FAIL protocol: ins_asked=%0b while ic_rdy=%0b mc_req=%0b, required no overlap", ins_asked, ic_rdy, mc_req);
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  task automatic row(input logic r, input logic a, input logic [31:0] ad, input logic m,
                     input logic [31:0] md, input logic ei, input logic em,
                     input logic [31:0] ema, input logic [31:0] eins, input logic ci);
    vec_t t;
    t.rst = r; t.rdy = 1'b1; t.ask = a; t.addr = ad; t.mrdy = m; t.mdata = md;
    t.e_icrdy = ei; t.e_mcreq = em; t.e_mcaddr = ema; t.e_ins = eins; t.c_ins = ci;
    v.push_back(t);
  endtask
  task automatic drive(input logic r, input logic rd, input logic a, input logic [31:0] ad,
                       input logic m, input logic [31:0] md);
    rst = r; rdy = rd; ins_asked = a; ins_addr = ad; mc_rdy = m; mc_data = md;
    @(posedge clk);
    #1;
    ins_asked = 1'b0; mc_rdy = 1'b0;
  endtask
  initial begin
    rst = 1'b1; rdy = 1'b1; ins_asked = 1'b0; ins_addr = '0; mc_rdy = 1'b0; mc_data = '0;
    row(1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,   32'h0,        1);
    row(0, 1, 32'h0,   0, 32'h0,        0, 1, 32'h0,   32'h0,        0);
    row(0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    row(0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    row(0, 0, 32'h0,   1, 32'h00000013, 1, 0, 32'h0,   32'h00000013, 1);
    row(0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    row(0, 1, 32'h0,   0, 32'h0,        1, 0, 32'h0,   32'h00000013, 1);
    row(0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    row(0, 1, 32'h400, 0, 32'h0,        0, 1, 32'h400, 32'h0,        0);
    row(0, 0, 32'h0,   1, 32'h00100093, 1, 0, 32'h0,   32'h00100093, 1);
    row(0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    row(0, 1, 32'h0,   0, 32'h0,        0, 1, 32'h0,   32'h0,        0);
    row(0, 0, 32'h0,   1, 32'h00000013, 1, 0, 32'h0,   32'h00000013, 1);
    row(0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    row(0, 1, 32'h6,   0, 32'h0,        0, 1, 32'h4,   32'h0,        0);
    row(0, 0, 32'h0,   1, 32'hABCD0001, 1, 0, 32'h0,   32'hABCD0001, 1);
    row(0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    row(0, 1, 32'h4,   0, 32'h0,        1, 0, 32'h0,   32'hABCD0001, 1);
    row(0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    row(0, 0, 32'h0,   1, 32'h00000055, 0, 0, 32'h0,   32'h0,        0);
    row(0, 1, 32'h4,   0, 32'h0,        1, 0, 32'h0,   32'hABCD0001, 1);
    row(0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    foreach (v[i]) begin
      drive(v[i].rst, v[i].rdy, v[i].ask, v[i].addr, v[i].mrdy, v[i].mdata);
      chk($sformatf("v%0d ic_rdy", i), {31'b0, ic_rdy}, {31'b0, v[i].e_icrdy});
      chk($sformatf("v%0d mc_req", i), {31'b0, mc_req}, {31'b0, v[i].e_mcreq});
      if (v[i].e_mcreq || v[i].rst) chk($sformatf("v%0d mc_addr", i), mc_addr, v[i].e_mcaddr);
      if (v[i].c_ins) chk($sformatf("v%0d ins", i), ins, v[i].e_ins);
    end
`ifdef ICACHE_PERF_EN
    chk("hit_cnt table", hit_cnt, 32'd3);
    chk("miss_cnt table", miss_cnt, 32'd4);
`endif
    drive(0, 1, 1, 32'h8, 0, 0);
    chk("rstmiss mc_req", {31'b0, mc_req}, 32'd1);
    chk("rstmiss mc_addr", mc_addr, 32'h8);
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    chk("rstmiss reset mc_req", {31'b0, mc_req}, 32'd0);
    chk("rstmiss reset ic_rdy", {31'b0, ic_rdy}, 32'd0);
    drive(0, 1, 0, 0, 1, 32'hDEADBEEF);
    chk("late mc_rdy ic_rdy", {31'b0, ic_rdy}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 0, 0);
      chk($sformatf("late idle%0d ic_rdy", k), {31'b0, ic_rdy}, 32'd0);
    end
    drive(0, 1, 1, 32'h8, 0, 0);
    chk("after rst miss mc_req", {31'b0, mc_req}, 32'd1);
    chk("after rst ic_rdy", {31'b0, ic_rdy}, 32'd0);
    drive(0, 1, 0, 0, 1, 32'h00000077);
    chk("refill ic_rdy", {31'b0, ic_rdy}, 32'd1);
    chk("refill ins", ins, 32'h00000077);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 32'hC, 0, 0);
    chk("stall mc_req", {31'b0, mc_req}, 32'd1);
    chk("stall mc_addr", mc_addr, 32'hC);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk($sformatf("stall%0d mc_req held", k), {31'b0, mc_req}, 32'd1);
      chk($sformatf("stall%0d ic_rdy", k), {31'b0, ic_rdy}, 32'd0);
    end
    drive(0, 1, 0, 0, 0, 0);
    chk("resume mc_req", {31'b0, mc_req}, 32'd0);
    chk("resume ic_rdy", {31'b0, ic_rdy}, 32'd0);
    drive(0, 1, 0, 0, 1, 32'h00000099);
    chk("stall fill ic_rdy", {31'b0, ic_rdy}, 32'd1);
    chk("stall fill ins", ins, 32'h00000099);
    drive(0, 1, 0, 0, 0, 0);
    chk("stall fill single pulse", {31'b0, ic_rdy}, 32'd0);
    drive(0, 1, 1, 32'hC, 0, 0);
    chk("stall line hit ic_rdy", {31'b0, ic_rdy}, 32'd1);
    chk("stall line hit ins", ins, 32'h00000099);
    chk("stall line hit mc_req", {31'b0, mc_req}, 32'd0);
`ifdef ICACHE_PERF_EN
    chk("hit_cnt end", hit_cnt, 32'd1);
    chk("miss_cnt end", miss_cnt, 32'd2);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
